// File: rtl/dct_pkg.sv
// Constants shared by the JPEG 2-D DCT datapath: coefficient widths and block dimension.
package dct_pkg;

    localparam int DCT_W_IN  = 20;
    localparam int DCT_FRAC  = 8;
    localparam int DCT_W_OUT = 12;
    localparam int DCT_N     = 8;

endpackage

// File: rtl/dct_round_sat.sv
// Round-half-up (toward +inf) of a signed fixed-point coefficient, then clamp to W_OUT bits.
module dct_round_sat #(
    parameter int W_IN  = 20,
    parameter int FRAC  = 8,
    parameter int W_OUT = 12
) (
    input  logic [W_IN-1:0]  x,
    output logic [W_OUT-1:0] y
);

    localparam logic signed [W_IN:0] HALF = (W_IN+1)'(1) << (FRAC-1);
    localparam logic signed [W_IN:0] MAXV = (W_IN+1)'((1 << (W_OUT-1)) - 1);
    localparam logic signed [W_IN:0] MINV = ~MAXV;

    // One guard bit so adding the half-LSB cannot wrap at the positive extreme.
    logic signed [W_IN:0] sum;
    logic signed [W_IN:0] q;

    assign sum = $signed({x[W_IN-1], x}) + HALF;
    assign q   = sum >>> FRAC;

    always_comb begin
        y = q[W_OUT-1:0];
        if (q > MAXV) begin
            y = MAXV[W_OUT-1:0];
        end else if (q < MINV) begin
            y = MINV[W_OUT-1:0];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows in (rounded/saturated at write), columns out.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int W_IN  = DCT_W_IN,
    parameter int FRAC  = DCT_FRAC,
    parameter int W_OUT = DCT_W_OUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_x0,
    input  logic [W_IN-1:0]  in_x1,
    input  logic [W_IN-1:0]  in_x2,
    input  logic [W_IN-1:0]  in_x3,
    input  logic [W_IN-1:0]  in_x4,
    input  logic [W_IN-1:0]  in_x5,
    input  logic [W_IN-1:0]  in_x6,
    input  logic [W_IN-1:0]  in_x7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_y0,
    output logic [W_OUT-1:0] out_y1,
    output logic [W_OUT-1:0] out_y2,
    output logic [W_OUT-1:0] out_y3,
    output logic [W_OUT-1:0] out_y4,
    output logic [W_OUT-1:0] out_y5,
    output logic [W_OUT-1:0] out_y6,
    output logic [W_OUT-1:0] out_y7,
    output logic [2:0]       out_col,
    output logic             out_last
);

    logic [W_IN-1:0]  in_x  [DCT_N];
    logic [W_OUT-1:0] rs_x  [DCT_N];
    logic [W_OUT-1:0] col_y [DCT_N];
    logic [W_OUT-1:0] mem   [2][DCT_N][DCT_N];

    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] wr_row;
    logic [2:0] rd_col;
    logic       wr_fire;
    logic       rd_fire;
    logic       wr_wrap;
    logic       rd_wrap;

    assign in_x[0] = in_x0;
    assign in_x[1] = in_x1;
    assign in_x[2] = in_x2;
    assign in_x[3] = in_x3;
    assign in_x[4] = in_x4;
    assign in_x[5] = in_x5;
    assign in_x[6] = in_x6;
    assign in_x[7] = in_x7;

    for (genvar c = 0; c < DCT_N; c++) begin : g_rs
        dct_round_sat #(
            .W_IN  (W_IN),
            .FRAC  (FRAC),
            .W_OUT (W_OUT)
        ) u_rs (
            .x (in_x[c]),
            .y (rs_x[c])
        );
    end

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign wr_wrap   = wr_fire && (wr_row == 3'd7);
    assign rd_wrap   = rd_fire && (rd_col == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < DCT_N; r++) begin
                    for (int c = 0; c < DCT_N; c++) begin
                        mem[b][r][c] <= '0;
                    end
                end
            end
        end else if (wr_fire) begin
            for (int c = 0; c < DCT_N; c++) begin
                mem[wr_bank][wr_row][c] <= rs_x[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_fire) begin
            wr_row <= wr_row + 3'd1;
            if (wr_wrap) begin
                wr_bank <= !wr_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_col  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_fire) begin
            rd_col <= rd_col + 3'd1;
            if (rd_wrap) begin
                rd_bank <= !rd_bank;
            end
        end
    end

    // A completing write and a completing drain always refer to different banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_wrap && (wr_bank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (rd_wrap && (rd_bank == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DCT_N; k++) begin
            col_y[k] = mem[rd_bank][k][rd_col];
        end
    end

    assign out_y0   = col_y[0];
    assign out_y1   = col_y[1];
    assign out_y2   = col_y[2];
    assign out_y3   = col_y[3];
    assign out_y4   = col_y[4];
    assign out_y5   = col_y[5];
    assign out_y6   = col_y[6];
    assign out_y7   = col_y[7];
    assign out_col  = rd_col;
    assign out_last = out_valid && (rd_col == 3'd7);

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf: a block/column queue model is checked against the DUT every cycle.
module tb_dct_transpose_buf;

    localparam int W_IN  = 20;
    localparam int W_OUT = 12;

    typedef logic [7:0][W_IN-1:0]  row_t;
    typedef logic [7:0][W_OUT-1:0] col_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  in_x [8];
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] out_y [8];
    logic [2:0]       out_col;
    logic             out_last;

    dct_transpose_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x0     (in_x[0]),
        .in_x1     (in_x[1]),
        .in_x2     (in_x[2]),
        .in_x3     (in_x[3]),
        .in_x4     (in_x[4]),
        .in_x5     (in_x[5]),
        .in_x6     (in_x[6]),
        .in_x7     (in_x[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y0    (out_y[0]),
        .out_y1    (out_y[1]),
        .out_y2    (out_y[2]),
        .out_y3    (out_y[3]),
        .out_y4    (out_y[4]),
        .out_y5    (out_y[5]),
        .out_y6    (out_y[6]),
        .out_y7    (out_y[7]),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rounding: floor((x + 0.5 LSB) / 256) done with integer division, then clamp.
    function automatic int rs_model(input int x);
        int s;
        int q;
        s = x + 128;
        if (s >= 0) q = s / 256;
        else        q = -((-s + 255) / 256);
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return q;
    endfunction

    // Model: completed blocks become 8 queued columns; a bank is busy until all its columns leave.
    col_t exp_q[$];
    int   pop_cnt;
    int   cur_blk [8][8];
    int   cur_rows;
    int   m_blocks;
    logic m_ready;
    logic m_valid;
    col_t m_front;
    col_t m_col;

    logic lit_mode = 1'b0;
    logic lit_round = 1'b0;
    logic stream_mode = 1'b0;
    int   stream_low = 0;
    int   stream_gap = 0;
    int   stream_cols = 0;
    int   round_tab [8] = '{2, 4095, 0, 2047, 2047, 2048, 2047, 0};

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pop_cnt  = 0;
            cur_rows = 0;
        end else begin
            m_blocks = (exp_q.size() + 7) / 8;
            m_ready  = (m_blocks < 2);
            m_valid  = (exp_q.size() > 0);
            chk("in_ready", int'(in_ready), int'(m_ready));
            chk("out_valid", int'(out_valid), int'(m_valid));
            if (m_valid) begin
                m_front = exp_q[0];
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("out_y%0d", k), int'(out_y[k]), int'(m_front[k]));
                end
                chk("out_col", int'(out_col), pop_cnt % 8);
                chk("out_last", int'(out_last), int'(pop_cnt % 8 == 7));
                if (lit_mode) begin
                    chk("lit_transpose_y0", int'(out_y[0]), pop_cnt % 8);
                    chk("lit_transpose_y7", int'(out_y[7]), 56 + pop_cnt % 8);
                end
                if (lit_round) begin
                    chk("lit_round_y0", int'(out_y[0]), round_tab[pop_cnt % 8]);
                    chk("lit_round_y1", int'(out_y[1]), 0);
                end
            end else begin
                chk("out_last_idle", int'(out_last), 0);
                if (stream_mode && stream_cols > 0 && stream_cols < 32) stream_gap++;
            end
            if (stream_mode && !in_ready) stream_low++;
            if (m_valid && out_ready) begin
                void'(exp_q.pop_front());
                pop_cnt++;
                if (stream_mode) stream_cols++;
            end
            if (in_valid && m_ready) begin
                for (int c = 0; c < 8; c++) cur_blk[cur_rows][c] = rs_model($signed(in_x[c]));
                cur_rows++;
                if (cur_rows == 8) begin
                    for (int c = 0; c < 8; c++) begin
                        for (int k = 0; k < 8; k++) m_col[k] = W_OUT'(cur_blk[k][c]);
                        exp_q.push_back(m_col);
                    end
                    cur_rows = 0;
                end
            end
        end
    end

    row_t rows_q[$];
    int   acc_cnt = 0;
    logic drv_busy = 1'b0;

    // Called at posedge+1; holds each row until the DUT accepts it.
    task automatic drive_rows();
        int   guard;
        logic acc;
        drv_busy = 1'b1;
        guard = 0;
        while (rows_q.size() > 0 && guard < 2000) begin
            in_valid = 1'b1;
            for (int c = 0; c < 8; c++) in_x[c] = rows_q[0][c];
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                void'(rows_q.pop_front());
                acc_cnt++;
            end
            guard++;
        end
        in_valid = 1'b0;
        if (rows_q.size() > 0) begin
            chk("drive_timeout", 0, 1);
            rows_q.delete();
        end
        drv_busy = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || cur_rows > 0 || drv_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_out_col"}, int'(out_col), 0);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_out_y%0d", tag, k), int'(out_y[k]), 0);
        @(posedge clk);
        #1;
    endtask

    row_t rw;
    int   v;

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) in_x[c] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset_outputs("reset");

        // Pin the reference rounding. 3000<<8 does not fit 20 bits, so the
        // largest-magnitude representable inputs exercise the clamp instead.
        chk("model_pos_half", rs_model(384), 2);
        chk("model_neg_half", rs_model(-384), -1);
        chk("model_small", rs_model(127), 0);
        chk("model_2047", rs_model(2047 << 8), 2047);
        chk("model_sat_hi", rs_model(524287), 2047);
        chk("model_min", rs_model(-524288), -2048);

        // Transpose of (8r+c)<<8: column c must read 8k+c.
        lit_mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) rw[c] = W_IN'((8 * r + c) << 8);
            rows_q.push_back(rw);
        end
        drive_rows();
        wait_drain();
        lit_mode = 1'b0;

        // Rounding and saturation lanes in row 0, zeros elsewhere.
        lit_round = 1'b1;
        rw[0] = W_IN'(384);
        rw[1] = W_IN'(-384);
        rw[2] = W_IN'(127);
        rw[3] = W_IN'(2047 << 8);
        rw[4] = W_IN'(524287);
        rw[5] = W_IN'(-524288);
        rw[6] = W_IN'(524160);
        rw[7] = W_IN'(-128);
        rows_q.push_back(rw);
        rw = '0;
        for (int r = 1; r < 8; r++) rows_q.push_back(rw);
        drive_rows();
        wait_drain();
        lit_round = 1'b0;

        // Backpressure: two banks fill, the 17th row stalls until block 0 drains.
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 8; c++) rw[c] = W_IN'(((r * 29 + c * 7) % 300 - 150) * 256 + (r % 3) * 100);
            rows_q.push_back(rw);
        end
        fork
            drive_rows();
        join_none
        #1;
        repeat (30) @(posedge clk);
        #1;
        chk("bp_accepted", acc_cnt, 16);
        chk("bp_in_ready_low", int'(in_ready), 0);
        out_ready = 1'b1;
        wait_drain();
        chk("bp_total_accepted", acc_cnt, 24);

        // Streaming: four blocks back-to-back with the sink always ready.
        stream_mode = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    v = ((r * 37 + c * 53 + b * 101) % 700 - 350) * 256 + ((r * 3 + c) % 4) * 64;
                    if (c == 7) v = (b % 2 == 1) ? 524287 - r : -524288 + r * 64;
                    rw[c] = W_IN'(v);
                end
                rows_q.push_back(rw);
            end
        end
        drive_rows();
        wait_drain();
        stream_mode = 1'b0;
        chk("stream_in_ready_low_cycles", stream_low, 0);
        chk("stream_column_gaps", stream_gap, 0);
        chk("stream_columns", stream_cols, 32);

        // Reset after five rows of a block; only the following block may appear.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 8; c++) rw[c] = W_IN'((900 + r * 8 + c) << 8);
            rows_q.push_back(rw);
        end
        drive_rows();
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset_outputs("midrst");
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) rw[c] = W_IN'(((r * 8 + c) * 5 - 100) << 8);
            rows_q.push_back(rw);
        end
        drive_rows();
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_idle_after", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
